// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
// fxp_pkg : shared Q8.8 constants, types and multiplier FSM states
// Revision 1.0
// ============================================================================
package fxp_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    typedef logic [WIDTH-1:0] q8_8_t;

    localparam q8_8_t Q_MAX = 16'h7FFF;
    localparam q8_8_t Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        ITER    = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fxp_round_sat.sv
`default_nettype none
// ============================================================================
// fxp_round_sat : round-half-away-from-zero and saturate a sign/magnitude product
// Revision 1.0
// ============================================================================
module fxp_round_sat #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic [2*WIDTH-1:0] mag_i,
    input  logic               sign_i,
    output logic [WIDTH-1:0]   res_o
);

    localparam int EW = 2*WIDTH + 1;
    localparam logic [EW-1:0]    HALF    = EW'(1) << (FRAC - 1);
    localparam logic [WIDTH-1:0] POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    logic [EW-1:0]    w_round;
    logic [WIDTH-1:0] w_lim;

    // Rounding on the magnitude makes ties round away from zero for both signs.
    always_comb begin
        w_round = ({1'b0, mag_i} + HALF) >> FRAC;
        w_lim   = '0;
        res_o   = '0;
        if (!sign_i) begin
            res_o = (w_round > {{(EW-WIDTH){1'b0}}, POS_LIM}) ? POS_LIM : w_round[WIDTH-1:0];
        end else begin
            w_lim = (w_round > {{(EW-WIDTH){1'b0}}, NEG_LIM}) ? NEG_LIM : w_round[WIDTH-1:0];
            res_o = ~w_lim + ONE_W;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fxp_multiplier.sv
`default_nettype none
// ============================================================================
// fxp_multiplier : free-running signed Q8.8 shift-add multiplier, 18-clock period
// Revision 1.0
// ============================================================================
module fxp_multiplier #(
    parameter int WIDTH = fxp_pkg::WIDTH,
    parameter int FRAC  = fxp_pkg::FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic [WIDTH-1:0] out,
    output logic             out_stb
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    fxp_pkg::state_t    state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_stb_q, out_stb_d;

    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH-1:0]   w_res;

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign w_abs1 = inp1[WIDTH-1] ? (~inp1 + ONE_W) : inp1;
    assign w_abs2 = inp2[WIDTH-1] ? (~inp2 + ONE_W) : inp2;

    fxp_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_round_sat (
        .mag_i  (acc_q),
        .sign_i (sign_q),
        .res_o  (w_res)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        out_d     = out_q;
        out_stb_d = 1'b0;
        case (state_q)
            fxp_pkg::CAPTURE: begin
                sign_d   = inp1[WIDTH-1] ^ inp2[WIDTH-1];
                mcand_d  = {{WIDTH{1'b0}}, w_abs1};
                mplier_d = w_abs2;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = fxp_pkg::ITER;
            end
            fxp_pkg::ITER: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = fxp_pkg::DONE;
                end
            end
            fxp_pkg::DONE: begin
                out_d     = w_res;
                out_stb_d = 1'b1;
                state_d   = fxp_pkg::CAPTURE;
            end
            default: begin
                state_d = fxp_pkg::CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= fxp_pkg::CAPTURE;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            out_stb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            out_stb_q <= out_stb_d;
        end
    end

    assign out     = out_q;
    assign out_stb = out_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_fxp_multiplier.sv
`default_nettype none
// ============================================================================
// tb_fxp_multiplier : scoreboard bench for the Q8.8 multiplier
// Revision 1.0
// ============================================================================
module tb_fxp_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inp1;
    logic [15:0] inp2;
    logic [15:0] out;
    logic        out_stb;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = 16'h0000;

    always #5 clk = ~clk;

    fxp_multiplier #(
        .WIDTH (16),
        .FRAC  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inp1    (inp1),
        .inp2    (inp2),
        .out     (out),
        .out_stb (out_stb)
    );

    // Reference: exact signed product, rounded half away from zero, then saturated.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        longint p;
        longint mag;
        longint r;
        bit     neg;
        p   = longint'($signed(a)) * longint'($signed(b));
        neg = a[15] ^ b[15];
        mag = (p < 0) ? -p : p;
        r   = (mag + 128) / 256;
        if (!neg) begin
            return (r > 32767) ? 16'h7FFF : 16'(r);
        end
        if (r > 32768) r = 32768;
        return 16'(-r);
    endfunction

    // Drive operands just before a capture edge and wait for the matching strobe.
    task automatic drive_wait(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e,
                              output int cyc, output bit to);
        inp1 = a;
        inp2 = b;
        exp_q.push_back(e);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (out_stb === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] e;
        bit          stb_seen;
        bit          early;
        rst      = 1'b0;
        inp1     = 16'hF780;
        inp2     = 16'hF580;
        stb_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_stb !== 1'b0) stb_seen = 1'b1;
        end
        tests++;
        if (out !== 16'h0000) begin
            fails++;
            $display("FAIL reset_out: got %h want 0000", out);
        end
        tests++;
        if (stb_seen) begin
            fails++;
            $display("FAIL reset_stb: got strobe during reset want none");
        end
        exp_q.push_back(16'h5940);
        rst   = 1'b1;
        early = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (out_stb !== 1'b0) early = 1'b1;
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL first_stb_early: got strobe before clock 18 want none");
        end
        @(negedge clk);
        tests++;
        if (out_stb !== 1'b1) begin
            fails++;
            $display("FAIL first_stb_timing: got out_stb=%b at clock 18 want 1", out_stb);
        end
        e = exp_q.pop_front();
        tests++;
        if (out !== e) begin
            fails++;
            $display("FAIL neg_neg_product: got %h want %h", out, e);
        end
        last_exp = e;
    endtask

    task automatic test_table(input string name, input logic [15:0] ta[4],
                              input logic [15:0] tb[4], input logic [15:0] te[4]);
        logic [15:0] e;
        int          cyc;
        bit          to;
        for (int i = 0; i < 4; i++) begin
            drive_wait(ta[i], tb[i], te[i], cyc, to);
            e = exp_q.pop_front();
            tests++;
            if (to) begin
                fails++;
                $display("FAIL %s[%0d]: got no strobe within 40 clocks want %h", name, i, e);
            end else if (out !== e) begin
                fails++;
                $display("FAIL %s[%0d]: %h*%h got %h want %h", name, i, ta[i], tb[i], out, e);
            end
            tests++;
            if (cyc != 18) begin
                fails++;
                $display("FAIL %s_period[%0d]: got %0d clocks want 18", name, i, cyc);
            end
            last_exp = e;
        end
    endtask

    task automatic test_saturation();
        test_table("saturation", '{16'h7F00, 16'h8000, 16'h8000, 16'h8100},
                                 '{16'h7F00, 16'h8000, 16'h0100, 16'h7F00},
                                 '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000});
    endtask

    task automatic test_rounding();
        test_table("rounding", '{16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF},
                               '{16'h0080, 16'h0080, 16'h007F, 16'h007F},
                               '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000});
    endtask

    task automatic test_zero();
        test_table("zero", '{16'h0000, 16'h8000, 16'hFFFF, 16'h0000},
                           '{16'h8000, 16'h0000, 16'h0001, 16'h0000},
                           '{16'h0000, 16'h0000, 16'h0000, 16'h0000});
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] e;
        int          cyc;
        bit          to;
        for (int i = 0; i < 12; i++) begin
            a = (i % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
            b = (i % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
            drive_wait(a, b, model(a, b), cyc, to);
            e = exp_q.pop_front();
            tests++;
            if (to || out !== e || cyc != 18) begin
                fails++;
                $display("FAIL back_to_back[%0d]: %h*%h got %h after %0d clocks want %h after 18",
                         i, a, b, out, cyc, e);
            end
            last_exp = e;
        end
    endtask

    task automatic test_midchange();
        logic [15:0] e;
        int          cyc;
        bit          to;
        bit          held_bad;
        inp1 = 16'h0300;
        inp2 = 16'h0280;
        exp_q.push_back(16'h0780);
        held_bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out !== last_exp || out_stb !== 1'b0) held_bad = 1'b1;
        end
        tests++;
        if (held_bad) begin
            fails++;
            $display("FAIL out_held: got %h want %h held without strobe", out, last_exp);
        end
        inp1 = 16'hFE00;
        inp2 = 16'h0140;
        cyc  = 5;
        to   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (out_stb === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        e = exp_q.pop_front();
        tests++;
        if (to || out !== e || cyc != 18) begin
            fails++;
            $display("FAIL midchange_captured: got %h after %0d clocks want %h after 18", out, cyc, e);
        end
        last_exp = e;
        drive_wait(16'hFE00, 16'h0140, 16'hFD80, cyc, to);
        e = exp_q.pop_front();
        tests++;
        if (to || out !== e || cyc != 18) begin
            fails++;
            $display("FAIL midchange_next: got %h after %0d clocks want %h after 18", out, cyc, e);
        end
        last_exp = e;
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        bit          stb_seen;
        bit          early;
        inp1     = 16'h7F00;
        inp2     = 16'h0200;
        stb_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_stb !== 1'b0) stb_seen = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_stb !== 1'b0) stb_seen = 1'b1;
        end
        tests++;
        if (out !== 16'h0000) begin
            fails++;
            $display("FAIL abort_out: got %h want 0000", out);
        end
        tests++;
        if (stb_seen) begin
            fails++;
            $display("FAIL abort_stb: got strobe for aborted operation want none");
        end
        inp1 = 16'h0180;
        inp2 = 16'hFF00;
        exp_q.push_back(16'hFE80);
        rst   = 1'b1;
        early = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (out_stb !== 1'b0) early = 1'b1;
        end
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if (early || out_stb !== 1'b1 || out !== e) begin
            fails++;
            $display("FAIL restart: got out=%h stb=%b early=%b want %h strobe at clock 18",
                     out, out_stb, early, e);
        end
        last_exp = e;
    endtask

    initial begin
        rst  = 1'b0;
        inp1 = '0;
        inp2 = '0;
        test_reset();
        test_saturation();
        test_rounding();
        test_zero();
        test_midchange();
        test_back_to_back();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
